// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the mux scan sequencer and its channel finder.
package mux_scan_sequencer_pkg;

    localparam int NUM_CH = 32;
    localparam int SEL_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    // Index of the lowest set bit; 0 when the vector is empty
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_next_channel.sv
// Combinational priority finder: next enabled channel strictly above cur, and
// the lowest enabled channel overall for wrap-around.
module mux_next_channel
    import mux_scan_sequencer_pkg::*;
(
    input  logic [31:0] mask,
    input  logic [4:0]  cur,
    output logic [4:0]  next_idx,
    output logic        found_above,
    output logic [4:0]  lowest_idx
);

    logic [31:0] above_s;

    // Keep only mask bits above cur; a shift past bit 31 leaves nothing above
    always_comb begin
        above_s     = mask & ~((32'd2 << cur) - 32'd1);
        found_above = |above_s;
        next_idx    = lowest_set(above_s);
        lowest_idx  = lowest_set(mask);
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans enabled channels of a 32:1 mux in ascending order, waits a settle time
// after each select change, then offers one sample per channel over valid/ready.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYC = 3,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [31:0] ch_mask,
    output logic [4:0]  sel,
    output logic        dec_en,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_e            state_r, state_s;
    logic [4:0]        sel_r, sel_s;
    logic              dec_en_r, dec_en_s;
    logic              valid_r, valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]       mask_r, mask_s;
    logic              cont_r, cont_s;

    logic [31:0]       search_mask_s;
    logic [4:0]        next_idx_s;
    logic [4:0]        lowest_idx_s;
    logic              found_above_s;

    // In IDLE the finder looks at the live mask so the first channel is ready at start
    always_comb begin
        if (state_r == ST_IDLE) begin
            search_mask_s = ch_mask;
        end else begin
            search_mask_s = mask_r;
        end
    end

    mux_next_channel u_next (
        .mask        (search_mask_s),
        .cur         (sel_r),
        .next_idx    (next_idx_s),
        .found_above (found_above_s),
        .lowest_idx  (lowest_idx_s)
    );

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_s  = state_r;
        sel_s    = sel_r;
        dec_en_s = dec_en_r;
        valid_s  = 1'b0;
        done_s   = 1'b0;
        cnt_s    = cnt_r;
        mask_s   = mask_r;
        cont_s   = cont_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (ch_mask != 32'd0) begin
                        mask_s   = ch_mask;
                        cont_s   = continuous;
                        sel_s    = lowest_idx_s;
                        dec_en_s = 1'b1;
                        cnt_s    = SETTLE_LD;
                        state_s  = ST_SETTLE;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    dec_en_s = 1'b0;
                    state_s  = ST_IDLE;
                end else if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    valid_s = 1'b1;
                    state_s = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                valid_s = 1'b1;
                if (sample_ready) begin
                    // Handshake completes even when stop arrives on the same edge
                    valid_s = 1'b0;
                    if (stop) begin
                        dec_en_s = 1'b0;
                        state_s  = ST_IDLE;
                    end else if (found_above_s) begin
                        sel_s   = next_idx_s;
                        cnt_s   = SETTLE_LD;
                        state_s = ST_SETTLE;
                    end else if (cont_r) begin
                        sel_s   = lowest_idx_s;
                        cnt_s   = SETTLE_LD;
                        state_s = ST_SETTLE;
                    end else begin
                        done_s   = 1'b1;
                        dec_en_s = 1'b0;
                        state_s  = ST_IDLE;
                    end
                end else if (stop) begin
                    valid_s  = 1'b0;
                    dec_en_s = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            default: begin
                dec_en_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sel_r    <= 5'd0;
            dec_en_r <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            mask_r   <= 32'd0;
            cont_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            dec_en_r <= dec_en_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            cnt_r    <= cnt_s;
            mask_r   <= mask_s;
            cont_r   <= cont_s;
        end
    end

    assign sel          = sel_r;
    assign dec_en       = dec_en_r;
    assign sample_valid = valid_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench for mux_scan_sequencer against a channel-list model.
module tb_mux_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [31:0] ch_mask;
    logic [4:0]  sel;
    logic        dec_en;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    localparam int SETTLE = 3;

    mux_scan_sequencer #(.SETTLE_CYC(SETTLE), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .ch_mask      (ch_mask),
        .sel          (sel),
        .dec_en       (dec_en),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given configuration
    task automatic kick(input logic [31:0] m, input logic cont);
        ch_mask    = m;
        continuous = cont;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (sel !== 5'd0 || dec_en !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got sel=%0d en=%0b v=%0b busy=%0b done=%0b exp all zero", sel, dec_en, sample_valid, busy, done);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Reach SAMPLE on channel 6, then reset asynchronously mid-cycle
        sample_ready = 1'b0;
        kick(32'h0000_0040, 1'b0);
        for (int k = 0; k < SETTLE + 1; k++) tick();
        checks++;
        if (sample_valid !== 1'b1 || sel !== 5'd6) begin
            errors++;
            $display("FAIL reset_pre got v=%0b sel=%0d exp v=1 sel=6", sample_valid, sel);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sel !== 5'd0 || dec_en !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got sel=%0d en=%0b v=%0b busy=%0b exp all zero", sel, dec_en, sample_valid, busy);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        int q[$];
        logic [31:0] m;
        m = 32'h8000_0005;
        for (int b = 0; b < 32; b++) if (m[b]) q.push_back(b);
        sample_ready = 1'b1;
        kick(m, 1'b0);
        foreach (q[i]) begin
            checks++;
            if (sel !== 5'(q[i]) || dec_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_sel got sel=%0d en=%0b busy=%0b exp sel=%0d en=1 busy=1", sel, dec_en, busy, q[i]);
            end
            for (int k = 1; k <= SETTLE + 1; k++) begin
                tick();
                checks++;
                if (sample_valid !== (k == SETTLE + 1)) begin
                    errors++;
                    $display("FAIL single_valid ch=%0d cyc=%0d got %0b exp %0b", q[i], k, sample_valid, (k == SETTLE + 1));
                end
            end
            tick();
            checks++;
            if (i == q.size() - 1) begin
                if (done !== 1'b1 || dec_en !== 1'b0 || busy !== 1'b0 || sel !== 5'd31) begin
                    errors++;
                    $display("FAIL single_end got done=%0b en=%0b busy=%0b sel=%0d exp 1 0 0 31", done, dec_en, busy, sel);
                end
            end else if (done !== 1'b0 || sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_mid got done=%0b v=%0b exp 0 0", done, sample_valid);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse got %0b exp 0", done);
        end
        sample_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        sample_ready = 1'b0;
        kick(32'h0000_0010, 1'b0);
        for (int k = 0; k < SETTLE + 1; k++) tick();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (sample_valid !== 1'b1 || sel !== 5'd4 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%0b sel=%0d busy=%0b exp 1 4 1", k, sample_valid, sel, busy);
            end
            tick();
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dec_en !== 1'b0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got done=%0b busy=%0b en=%0b v=%0b exp 1 0 0 0", done, busy, dec_en, sample_valid);
        end
        tick();
    endtask

    task automatic test_continuous();
        sample_ready = 1'b1;
        kick(32'h0000_0100, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= SETTLE + 1; k++) begin
                tick();
                checks++;
                if (sample_valid !== (k == SETTLE + 1) || sel !== 5'd8 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL cont_round r=%0d cyc=%0d got v=%0b sel=%0d done=%0b", r, k, sample_valid, sel, done);
                end
            end
            tick();
            checks++;
            if (sample_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || sel !== 5'd8 || dec_en !== 1'b1) begin
                errors++;
                $display("FAIL cont_wrap got v=%0b busy=%0b done=%0b sel=%0d en=%0b exp 0 1 0 8 1", sample_valid, busy, done, sel, dec_en);
            end
        end
        sample_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop got busy=%0b en=%0b done=%0b exp 0 0 0", busy, dec_en, done);
        end
        tick();
    endtask

    task automatic test_empty_mask();
        kick(32'h0000_0000, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dec_en !== 1'b0) begin
            errors++;
            $display("FAIL empty_start got done=%0b busy=%0b en=%0b exp 1 0 0", done, busy, dec_en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_after got done=%0b busy=%0b exp 0 0", done, busy);
        end
    endtask

    task automatic test_stop();
        sample_ready = 1'b0;
        kick(32'h0000_0003, 1'b0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_en !== 1'b0 || done !== 1'b0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_settle got busy=%0b en=%0b done=%0b v=%0b exp 0 0 0 0", busy, dec_en, done, sample_valid);
        end
        for (int k = 0; k < SETTLE + 2; k++) begin
            tick();
            checks++;
            if (sample_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL stop_quiet cyc=%0d got v=%0b done=%0b exp 0 0", k, sample_valid, done);
            end
        end
        kick(32'h0000_0003, 1'b0);
        for (int k = 0; k < SETTLE + 1; k++) tick();
        stop         = 1'b1;
        sample_ready = 1'b1;
        tick();
        stop         = 1'b0;
        sample_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_en !== 1'b0 || done !== 1'b0 || sample_valid !== 1'b0 || sel !== 5'd0) begin
            errors++;
            $display("FAIL stop_accept got busy=%0b en=%0b done=%0b v=%0b sel=%0d exp 0 0 0 0 0", busy, dec_en, done, sample_valid, sel);
        end
        tick();
    endtask

    // Random sparse masks with random backpressure; inputs scrambled while busy
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] m;
            int q[$];
            m = $urandom() & $urandom() & $urandom();
            if (m == 32'd0) m = 32'h0000_0001 << $urandom_range(31, 0);
            q = {};
            for (int b = 0; b < 32; b++) if (m[b]) q.push_back(b);
            sample_ready = 1'b0;
            kick(m, 1'b0);
            ch_mask    = $urandom();
            continuous = 1'b1;
            foreach (q[i]) begin
                int d;
                d = $urandom_range(3, 0);
                checks++;
                if (sel !== 5'(q[i]) || dec_en !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_sel it=%0d got sel=%0d en=%0b exp sel=%0d en=1", it, sel, dec_en, q[i]);
                end
                for (int k = 1; k <= SETTLE + 1 + d; k++) begin
                    tick();
                    checks++;
                    if (sample_valid !== (k >= SETTLE + 1) || sel !== 5'(q[i])) begin
                        errors++;
                        $display("FAIL rand_wait it=%0d ch=%0d cyc=%0d got v=%0b sel=%0d", it, q[i], k, sample_valid, sel);
                    end
                end
                sample_ready = 1'b1;
                tick();
                sample_ready = 1'b0;
                checks++;
                if (done !== (i == q.size() - 1) || busy !== (i != q.size() - 1)) begin
                    errors++;
                    $display("FAIL rand_accept it=%0d ch=%0d got done=%0b busy=%0b", it, q[i], done, busy);
                end
            end
            continuous = 1'b0;
            tick();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        continuous   = 1'b0;
        ch_mask      = 32'd0;
        sample_ready = 1'b0;
        test_reset();
        test_single_pass();
        test_backpressure();
        test_continuous();
        test_empty_mask();
        test_stop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
